// File: rtl/game_pkg.sv
// Purpose: shared state encoding and keyboard scan codes for the match controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [2:0] {
        S_MENU       = 3'd0,
        S_READY      = 3'd1,
        S_RUN        = 3'd2,
        S_PAUSED     = 3'd3,
        S_ROUND_OVER = 3'd4,
        S_MATCH_OVER = 3'd5
    } game_state_t;

    localparam logic [7:0] KEY_ENTER  = 8'h28;
    localparam logic [7:0] KEY_ESCAPE = 8'h29;
    localparam logic [7:0] KEY_UP     = 8'h52;
    localparam logic [7:0] KEY_W      = 8'h1A;
    localparam logic [7:0] KEY_DOWN   = 8'h51;
    localparam logic [7:0] KEY_S      = 8'h16;

endpackage

// File: rtl/key_edge.sv
// Purpose: turns a level keycode into a one-cycle press pulse (new non-zero code).
// Latency: press_o is combinational from keycode_i against last cycle's code.
// Backpressure: none; a held key yields a single press.
// Ports: clk_i clock, keycode_i current code (0 = none), press_o press pulse.
module key_edge (
    input  logic       clk_i,
    input  logic [7:0] keycode_i,
    output logic       press_o
);

    logic [7:0] prev_q;

    // Loads every cycle, reset included, so a key held through reset never fires.
    always_ff @(posedge clk_i) begin
        prev_q <= keycode_i;
    end

    assign press_o = (keycode_i != 8'h00) && (keycode_i != prev_q);

endmodule

// File: rtl/game_match_ctrl.sv
// Purpose: multi-player round/match state machine (menu, countdown, play, pause, results).
// Latency: all outputs registered; inputs take effect on the next rising edge.
// Backpressure: none; key actions fire once per press, Tick/Crash are sampled pulses.
// Ports: Clk, Reset/Reset_Game (sync, active-high), keycode, Tick, Crash[player] in;
//        Game_State, Map_Select, Load_Background, Alive, Scores (packed), Countdown,
//        Winner, Winner_Valid, Draw out.
module game_match_ctrl
    import game_pkg::*;
#(
    parameter int  NUM_PLAYERS = 2,
    parameter int  WIN_ROUNDS  = 3,
    parameter int  NUM_MAPS    = 4,
    parameter int  COUNT_TICKS = 3,
    localparam int MAP_W   = ($clog2(NUM_MAPS) > 1) ? $clog2(NUM_MAPS) : 1,
    localparam int SCORE_W = $clog2(WIN_ROUNDS + 1),
    localparam int PID_W   = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Reset_Game,
    input  logic [7:0]                     keycode,
    input  logic                           Tick,
    input  logic [NUM_PLAYERS-1:0]         Crash,
    output logic [2:0]                     Game_State,
    output logic [MAP_W-1:0]               Map_Select,
    output logic                           Load_Background,
    output logic [NUM_PLAYERS-1:0]         Alive,
    output logic [NUM_PLAYERS*SCORE_W-1:0] Scores,
    output logic [3:0]                     Countdown,
    output logic [PID_W-1:0]               Winner,
    output logic                           Winner_Valid,
    output logic                           Draw
);

    logic rst;
    logic key_press;
    logic up_p, dn_p, ent_p, esc_p;

    game_state_t                    state_q, state_d;
    logic [MAP_W-1:0]               map_q, map_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic [NUM_PLAYERS-1:0]         alive_q, alive_d;
    logic [3:0]                     count_q, count_d;
    logic [PID_W-1:0]               winner_q, winner_d;
    logic                           wv_q, wv_d;
    logic                           draw_q, draw_d;
    logic                           lb_q, lb_d;

    logic [NUM_PLAYERS-1:0]         next_alive;
    int                             n_alive;
    logic [SCORE_W-1:0]             score_inc;

    assign rst = Reset | Reset_Game;

    key_edge u_key_edge (
        .clk_i     (Clk),
        .keycode_i (keycode),
        .press_o   (key_press)
    );

    assign up_p  = key_press && ((keycode == KEY_UP)   || (keycode == KEY_W));
    assign dn_p  = key_press && ((keycode == KEY_DOWN) || (keycode == KEY_S));
    assign ent_p = key_press && (keycode == KEY_ENTER);
    assign esc_p = key_press && (keycode == KEY_ESCAPE);

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        scores_d   = scores_q;
        alive_d    = alive_q;
        count_d    = count_q;
        winner_d   = winner_q;
        wv_d       = wv_q;
        draw_d     = draw_q;
        lb_d       = 1'b0;
        score_inc  = '0;
        next_alive = alive_q & ~Crash;
        n_alive    = 0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            n_alive = n_alive + int'(next_alive[i]);
        end

        case (state_q)
            S_MENU: begin
                if (ent_p) begin
                    state_d  = S_READY;
                    scores_d = '0;
                end else if (up_p) begin
                    map_d = (map_q == MAP_W'(NUM_MAPS - 1)) ? '0 : map_q + 1'b1;
                end else if (dn_p) begin
                    map_d = (map_q == '0) ? MAP_W'(NUM_MAPS - 1) : map_q - 1'b1;
                end
            end
            S_READY: begin
                if (Tick) begin
                    if (count_q == 4'd1) begin
                        count_d = 4'd0;
                        state_d = S_RUN;
                    end else begin
                        count_d = count_q - 4'd1;
                    end
                end
            end
            S_RUN: begin
                alive_d = next_alive;
                if (n_alive == 1) begin
                    // Exactly one survivor: credit it; a round-ending crash beats Escape.
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (next_alive[i]) begin
                            score_inc = scores_q[i*SCORE_W +: SCORE_W] + 1'b1;
                            scores_d[i*SCORE_W +: SCORE_W] = score_inc;
                            winner_d = PID_W'(i);
                        end
                    end
                    wv_d    = 1'b1;
                    state_d = (score_inc == SCORE_W'(WIN_ROUNDS)) ? S_MATCH_OVER : S_ROUND_OVER;
                end else if (n_alive == 0) begin
                    draw_d  = 1'b1;
                    state_d = S_ROUND_OVER;
                end else if (esc_p) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (esc_p || ent_p) begin
                    state_d = S_RUN;
                end
            end
            S_ROUND_OVER: begin
                if (ent_p) begin
                    state_d = S_READY;
                end
            end
            S_MATCH_OVER: begin
                if (ent_p) begin
                    state_d = S_MENU;
                end
            end
            default: state_d = S_MENU;
        endcase

        // Every fresh round starts with everyone alive and a full countdown.
        if ((state_d == S_READY) && (state_q != S_READY)) begin
            alive_d = '1;
            count_d = 4'(COUNT_TICKS);
            wv_d    = 1'b0;
            draw_d  = 1'b0;
        end

        // Screen changes only; RUN<->PAUSED keeps the current background.
        lb_d = (state_d != state_q) &&
               (state_d inside {S_MENU, S_READY, S_ROUND_OVER, S_MATCH_OVER});
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q  <= S_MENU;
            map_q    <= '0;
            scores_q <= '0;
            alive_q  <= '0;
            count_q  <= '0;
            winner_q <= '0;
            wv_q     <= 1'b0;
            draw_q   <= 1'b0;
            lb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            map_q    <= map_d;
            scores_q <= scores_d;
            alive_q  <= alive_d;
            count_q  <= count_d;
            winner_q <= winner_d;
            wv_q     <= wv_d;
            draw_q   <= draw_d;
            lb_q     <= lb_d;
        end
    end

    assign Game_State      = state_q;
    assign Map_Select      = map_q;
    assign Load_Background = lb_q;
    assign Alive           = alive_q;
    assign Scores          = scores_q;
    assign Countdown       = count_q;
    assign Winner          = winner_q;
    assign Winner_Valid    = wv_q;
    assign Draw            = draw_q;

endmodule

// File: tb/tb_game_match_ctrl.sv
// Purpose: self-checking bench for game_match_ctrl (directed scenarios plus random play).
// Latency: compares every output one cycle after each stimulus edge.
// Backpressure: n/a.
module tb_game_match_ctrl;

    localparam int NP     = 2;
    localparam int WIN    = 3;
    localparam int NMAPS  = 4;
    localparam int TICKS  = 3;
    localparam int SW     = 2;

    localparam int ST_MENU  = 0;
    localparam int ST_READY = 1;
    localparam int ST_RUN   = 2;
    localparam int ST_PAUSE = 3;
    localparam int ST_ROUND = 4;
    localparam int ST_MATCH = 5;

    localparam logic [7:0] K_ENT = 8'h28;
    localparam logic [7:0] K_ESC = 8'h29;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Reset_Game = 1'b0;
    logic [7:0]    keycode = 8'h00;
    logic          Tick = 1'b0;
    logic [NP-1:0] Crash = '0;
    logic [2:0]    Game_State;
    logic [1:0]    Map_Select;
    logic          Load_Background;
    logic [NP-1:0] Alive;
    logic [NP*SW-1:0] Scores;
    logic [3:0]    Countdown;
    logic          Winner;
    logic          Winner_Valid;
    logic          Draw;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference state
    int         m_state, m_map, m_count, m_winner;
    int         m_scores[NP];
    logic [1:0] m_alive;
    bit         m_wv, m_draw, m_lb;
    logic [7:0] m_prev = 8'h00;

    always #5 Clk = ~Clk;

    game_match_ctrl #(
        .NUM_PLAYERS (NP),
        .WIN_ROUNDS  (WIN),
        .NUM_MAPS    (NMAPS),
        .COUNT_TICKS (TICKS)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Reset_Game      (Reset_Game),
        .keycode         (keycode),
        .Tick            (Tick),
        .Crash           (Crash),
        .Game_State      (Game_State),
        .Map_Select      (Map_Select),
        .Load_Background (Load_Background),
        .Alive           (Alive),
        .Scores          (Scores),
        .Countdown       (Countdown),
        .Winner          (Winner),
        .Winner_Valid    (Winner_Valid),
        .Draw            (Draw)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] k, input logic t, input logic [1:0] c, input logic r);
        bit         press;
        int         nxt;
        logic [1:0] survivors;
        press  = (k != 8'h00) && (k != m_prev);
        m_prev = k;
        if (r) begin
            m_state = ST_MENU; m_map = 0; m_alive = '0; m_count = 0;
            m_winner = 0; m_wv = 0; m_draw = 0; m_lb = 0;
            for (int p = 0; p < NP; p++) m_scores[p] = 0;
            return;
        end
        nxt = m_state;
        case (m_state)
            ST_MENU: begin
                if (press && k == K_ENT) begin
                    for (int p = 0; p < NP; p++) m_scores[p] = 0;
                    nxt = ST_READY;
                end else if (press && (k == 8'h52 || k == 8'h1A)) begin
                    m_map = (m_map + 1) % NMAPS;
                end else if (press && (k == 8'h51 || k == 8'h16)) begin
                    m_map = (m_map + NMAPS - 1) % NMAPS;
                end
            end
            ST_READY: begin
                if (t) begin
                    m_count = m_count - 1;
                    if (m_count == 0) nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                survivors = m_alive & ~c;
                m_alive   = survivors;
                if ($countones(survivors) == 1) begin
                    m_winner = survivors[1] ? 1 : 0;
                    m_scores[m_winner] = m_scores[m_winner] + 1;
                    m_wv = 1;
                    nxt = (m_scores[m_winner] == WIN) ? ST_MATCH : ST_ROUND;
                end else if (survivors == 2'b00) begin
                    m_draw = 1;
                    nxt = ST_ROUND;
                end else if (press && k == K_ESC) begin
                    nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: if (press && (k == K_ESC || k == K_ENT)) nxt = ST_RUN;
            ST_ROUND: if (press && k == K_ENT) nxt = ST_READY;
            ST_MATCH: if (press && k == K_ENT) nxt = ST_MENU;
            default:  nxt = ST_MENU;
        endcase
        if (nxt == ST_READY && m_state != ST_READY) begin
            m_alive = 2'b11; m_count = TICKS; m_wv = 0; m_draw = 0;
        end
        m_lb    = (nxt != m_state) && (nxt != ST_RUN) && (nxt != ST_PAUSE);
        m_state = nxt;
    endtask

    task automatic compare_all();
        check("state", int'(Game_State), m_state);
        check("map", int'(Map_Select), m_map);
        check("load_bg", int'(Load_Background), int'(m_lb));
        check("alive", int'(Alive), int'(m_alive));
        check("countdown", int'(Countdown), m_count);
        check("winner", int'(Winner), m_winner);
        check("winner_valid", int'(Winner_Valid), int'(m_wv));
        check("draw", int'(Draw), int'(m_draw));
        for (int p = 0; p < NP; p++)
            check($sformatf("score%0d", p), int'(Scores[p*SW +: SW]), m_scores[p]);
    endtask

    task automatic step(input logic [7:0] k, input logic t, input logic [1:0] c,
                        input logic r, input logic rg);
        @(negedge Clk);
        keycode = k; Tick = t; Crash = c; Reset = r; Reset_Game = rg;
        @(posedge Clk);
        model_step(k, t, c, r | rg);
        #1;
        compare_all();
    endtask

    task automatic key(input logic [7:0] k);
        step(k, 1'b0, 2'b00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic countdown();
        for (int i = 0; i < TICKS; i++) step(8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        int         lbs;
        logic [7:0] k, last_k;
        logic       t, rs, rg;
        logic [1:0] c;

        step(8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        check("rst_state", int'(Game_State), ST_MENU);
        check("rst_lb", int'(Load_Background), 0);

        // Map wrap both ways
        step(8'h51, 1'b0, 2'b00, 1'b0, 1'b0);  check("map_dn1", int'(Map_Select), 3);
        step(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        step(8'h16, 1'b0, 2'b00, 1'b0, 1'b0);  check("map_dn2", int'(Map_Select), 2);
        step(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        step(8'h52, 1'b0, 2'b00, 1'b0, 1'b0);  check("map_up1", int'(Map_Select), 3);
        step(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        step(8'h1A, 1'b0, 2'b00, 1'b0, 1'b0);  check("map_up2", int'(Map_Select), 0);
        step(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // Enter held 10 cycles acts once
        lbs = 0;
        for (int i = 0; i < 10; i++) begin
            step(K_ENT, 1'b0, 2'b00, 1'b0, 1'b0);
            lbs += int'(Load_Background);
        end
        check("hold_lb_cycles", lbs, 1);
        check("hold_state", int'(Game_State), ST_READY);
        check("hold_count", int'(Countdown), 3);
        step(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

        // Crash ignored in READY, countdown to RUN
        step(8'h00, 1'b0, 2'b11, 1'b0, 1'b0);  check("ready_crash_alive", int'(Alive), 3);
        step(8'h00, 1'b1, 2'b00, 1'b0, 1'b0);  check("cd_2", int'(Countdown), 2);
        step(8'h00, 1'b1, 2'b00, 1'b0, 1'b0);  check("cd_1", int'(Countdown), 1);
        step(8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
        check("cd_run", int'(Game_State), ST_RUN);
        check("cd_0", int'(Countdown), 0);

        // Player 0 crashes: player 1 takes the round
        step(8'h00, 1'b0, 2'b01, 1'b0, 1'b0);
        check("p1_win_winner", int'(Winner), 1);
        check("p1_win_score", int'(Scores[SW +: SW]), 1);
        check("p1_win_state", int'(Game_State), ST_ROUND);

        // Simultaneous double crash is a draw
        key(K_ENT);
        countdown();
        step(8'h00, 1'b0, 2'b11, 1'b0, 1'b0);
        check("draw_flag", int'(Draw), 1);
        check("draw_score1", int'(Scores[SW +: SW]), 1);
        check("draw_score0", int'(Scores[0 +: SW]), 0);

        // Player 0 wins three rounds -> match
        for (int r = 0; r < WIN; r++) begin
            key(K_ENT);
            countdown();
            step(8'h00, 1'b0, 2'b10, 1'b0, 1'b0);
        end
        check("match_state", int'(Game_State), ST_MATCH);
        check("match_winner", int'(Winner), 0);
        key(K_ENT);
        check("menu_after_match", int'(Game_State), ST_MENU);
        check("menu_score_held", int'(Scores[0 +: SW]), 3);

        // Pause/resume, then Escape colliding with a round-ending crash
        key(K_ENT);
        countdown();
        step(K_ESC, 1'b0, 2'b00, 1'b0, 1'b0);  check("pause_state", int'(Game_State), ST_PAUSE);
        check("pause_lb", int'(Load_Background), 0);
        step(8'h00, 1'b0, 2'b01, 1'b0, 1'b0);  check("pause_alive", int'(Alive), 3);
        step(K_ESC, 1'b0, 2'b00, 1'b0, 1'b0);  check("resume_state", int'(Game_State), ST_RUN);
        step(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        step(K_ESC, 1'b0, 2'b10, 1'b0, 1'b0);
        check("esc_crash_state", int'(Game_State), ST_ROUND);

        // Reset mid-round
        key(K_ENT);
        countdown();
        step(8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        check("midrst_state", int'(Game_State), ST_MENU);
        check("midrst_scores", int'(Scores), 0);
        check("midrst_alive", int'(Alive), 0);

        // Random play against the reference model
        last_k = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 8))
                0, 1, 2: k = 8'h00;
                3:       k = last_k;
                4, 5:    k = K_ENT;
                6:       k = K_ESC;
                7: begin
                    case ($urandom_range(0, 3))
                        0:       k = 8'h52;
                        1:       k = 8'h51;
                        2:       k = 8'h1A;
                        default: k = 8'h16;
                    endcase
                end
                default: k = 8'($urandom_range(1, 255));
            endcase
            t  = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rs = ($urandom_range(0, 399) == 0);
            rg = ($urandom_range(0, 399) == 0);
            step(k, t, c, rs, rg);
            last_k = k;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_match_ctrl.md
GAME_MATCH_CTRL -- requirements
Module: game_match_ctrl

Interface
REQ-001 NUM_PLAYERS, default 2, number of players, legal range 2..4.
REQ-002 WIN_ROUNDS, default 3, round wins needed to take the match, legal range 1..7.
REQ-003 NUM_MAPS, default 4, number of selectable maps, legal range 2..8.
REQ-004 COUNT_TICKS, default 3, Tick pulses in the pre-round countdown, legal range 1..15.
REQ-005 Clk  in  1  system clock; all state updates on the rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Reset_Game  in  1  synchronous return-to-menu; identical effect to Reset.
REQ-008 keycode  in  8  current keyboard keycode; 0 means no key.
REQ-009 Tick  in  1  one-cycle frame pulse.
REQ-010 Crash  in  NUM_PLAYERS  per-player crash pulses; bit i is player i.
REQ-011 Game_State  out  3  encoded current state.
REQ-012 Map_Select  out  MAP_W=max(1,clog2(NUM_MAPS))  selected map.
REQ-013 Load_Background  out  1  one-cycle pulse on each screen change.
REQ-014 Alive  out  NUM_PLAYERS  players still alive in the current round.
REQ-015 Scores  out  NUM_PLAYERS*SCORE_W  packed; player i at [i*SCORE_W +: SCORE_W]; SCORE_W=clog2(WIN_ROUNDS+1).
REQ-016 Countdown  out  4  remaining countdown ticks.
REQ-017 Winner  out  PID_W=max(1,clog2(NUM_PLAYERS))  index of the last round or match winner.
REQ-018 Winner_Valid  out  1  Winner is meaningful.
REQ-019 Draw  out  1  last round ended with no survivor.

Function
REQ-020 A key press is defined as keycode!=0 and keycode differing from its value on the previous cycle; all key actions use presses only, so a held key acts once.
REQ-021 State encoding: MENU=0, READY=1, RUN=2, PAUSED=3, ROUND_OVER=4, MATCH_OVER=5.
REQ-022 MENU, Up press (0x52 or 0x1A): Map_Select increments; NUM_MAPS-1 wraps to 0.
REQ-023 MENU, Down press (0x51 or 0x16): Map_Select decrements; 0 wraps to NUM_MAPS-1.
REQ-024 MENU, Enter press (0x28): go to READY and clear all Scores.
REQ-025 On every entry to READY: Alive set to all ones, Countdown set to COUNT_TICKS, Winner_Valid and Draw cleared.
REQ-026 READY: each Tick decrements Countdown; a Tick seen with Countdown==1 sets Countdown to 0 and enters RUN; Crash and keys are ignored.
REQ-027 RUN: next_alive = Alive & ~Crash; all Crash bits in one cycle count as simultaneous.
REQ-028 RUN, popcount(next_alive)==1: that player's score increments, Winner gets its index, Winner_Valid=1; if the new score equals WIN_ROUNDS go to MATCH_OVER, otherwise go to ROUND_OVER.
REQ-029 RUN, popcount(next_alive)==0: Draw=1, no score change, go to ROUND_OVER.
REQ-030 RUN, Escape press (0x29) with no round-ending crash: go to PAUSED; a round-ending crash in the same cycle takes priority.
REQ-031 PAUSED: Crash ignored and Alive frozen; Escape or Enter press returns to RUN.
REQ-032 ROUND_OVER, Enter press: go to READY.
REQ-033 MATCH_OVER, Enter press: go to MENU; Scores, Winner and Map_Select are held.
REQ-034 Load_Background is registered and high for exactly the first cycle of MENU (except after reset), READY, ROUND_OVER and MATCH_OVER; it is never asserted on RUN<->PAUSED transitions.
REQ-035 Scores never exceed WIN_ROUNDS.
REQ-036 All outputs are registered.

Reset
REQ-037 Reset or Reset_Game forces the following values: Game_State=MENU, Map_Select=0, Scores=0, Alive=0, Countdown=0, Winner=0, Winner_Valid=0, Draw=0, Load_Background=0.
REQ-038 During reset the previous-keycode register loads the current keycode, so a key held across reset does not fire.
REQ-039 Reset asserted mid-round abandons the round on the next edge, with no score change.

Structure
REQ-040 Package game_pkg holds the state enum and the keycode constants (Enter, Escape, Up/W, Down/S).
REQ-041 Sub-module key_edge (registered previous keycode plus press pulse) is instantiated once.

Verification
REQ-042 Map wrap, NUM_MAPS=4: two Down presses from reset -> Map_Select 3 then 2; then two Up presses -> Map_Select 3 then 0.
REQ-043 Enter held 10 cycles in MENU -> exactly one transition, to READY; Load_Background high for 1 cycle; Countdown=3.
REQ-044 Countdown: 3 Tick pulses in READY -> Countdown reads 2, 1, then RUN with Countdown=0; Crash=2'b11 in READY -> Alive stays 2'b11.
REQ-045 Crash=2'b01 in RUN -> Winner=1, Scores[player1]=1, ROUND_OVER; Crash=2'b11 in RUN -> Draw=1, Scores unchanged.
REQ-046 WIN_ROUNDS=3: player 0 wins three rounds -> MATCH_OVER with Winner=0; Enter -> MENU with Scores still showing 3.
REQ-047 Escape press in the same cycle as Crash=2'b10 -> ROUND_OVER, not PAUSED; Reset pulse during RUN -> MENU with all outputs at their reset values.
